// File: rtl/sp_ram_arb.sv
// Two-port arbiter in front of a registered single-port RAM, with tagged read responses.
// Define SP_RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority; round-robin otherwise.
module sp_ram_arb #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_din,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_din,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic grant_a;
  logic grant_b;
  logic rd_accept;
  logic s0_valid;
  logic s0_owner_b;
  logic s1_valid;
  logic s1_owner_b;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_a = a_valid && !rst;
    grant_b = b_valid && !a_valid && !rst;
  end
`else
  logic last_b;  // 1 when B won the most recent accept

  always_comb begin
    if (a_valid && b_valid) begin
      grant_a = last_b && !rst;
      grant_b = !last_b && !rst;
    end else begin
      grant_a = a_valid && !rst;
      grant_b = b_valid && !rst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (grant_a) begin
      last_b <= 1'b0;
    end else if (grant_b) begin
      last_b <= 1'b1;
    end
  end
`endif

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (grant_a) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_din;
    end else if (grant_b) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_din;
    end
  end

  assign rd_accept = (grant_a && !a_we) || (grant_b && !b_we);

  // Two stages match the RAM's input and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      s0_owner_b <= 1'b0;
      s1_valid   <= 1'b0;
      s1_owner_b <= 1'b0;
    end else begin
      s0_valid   <= rd_accept;
      s0_owner_b <= grant_b;
      s1_valid   <= s0_valid;
      s1_owner_b <= s0_owner_b;
    end
  end

  assign a_rvalid = s1_valid && !s1_owner_b;
  assign b_rvalid = s1_valid && s1_owner_b;
  assign a_rdata  = a_rvalid ? ram_dout : '0;
  assign b_rdata  = b_rvalid ? ram_dout : '0;

endmodule
